// File: rtl/risc_v_mike_mem_arbiter.sv
// Two-port memory bus arbiter for the multicycle core. It shares the bus between
// the CPU port and the debug/loader port with round-robin and a burst cap. Grants
// are combinational from the registered owner state. Read data comes back one
// cycle after the read grant.
// Optional build macro RISC_V_MIKE_ARB_DBG_HALT_EN adds dbg_halt/halt_ack. While
// halt is active the CPU is locked out and the debug port holds the bus uncapped.
module risc_v_mike_mem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner
`ifdef RISC_V_MIKE_ARB_DBG_HALT_EN
  ,
  input  logic              dbg_halt,
  output logic              halt_ack
`endif
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CPU  = 2'b01;
  localparam logic [1:0] ST_DBG  = 2'b10;

  localparam int unsigned     CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_dbg_q, last_dbg_d;
  logic             cpu_rvalid_q, dbg_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic             halt;
  logic             cpu_ok;
  logic             cnt_at_cap;

`ifdef RISC_V_MIKE_ARB_DBG_HALT_EN
  assign halt = dbg_halt;
`else
  assign halt = 1'b0;
`endif

  assign cpu_ok     = cpu_req & ~halt;
  assign cnt_at_cap = (cnt_q == CNT_LAST);

  assign cpu_gnt = (state_q == ST_CPU) & cpu_req;
  assign dbg_gnt = (state_q == ST_DBG) & dbg_req;
  // Gated by rst so that every output reads 0 while reset is held.
  assign cpu_stall = rst & cpu_req & ~cpu_gnt;
  assign owner     = state_q;

  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;

  // Drive the memory bus from whichever port holds a grant this cycle.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_write = cpu_we;
      mem_read  = ~cpu_we;
    end else if (dbg_gnt) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_write = dbg_we;
      mem_read  = ~dbg_we;
    end
  end

  // Next owner, burst count and round-robin history.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_dbg_d = last_dbg_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (cpu_ok && dbg_req) state_d = last_dbg_q ? ST_CPU : ST_DBG;
        else if (cpu_ok)       state_d = ST_CPU;
        else if (dbg_req)      state_d = ST_DBG;
      end
      ST_CPU: begin
        if (cpu_ok) begin
          if (!cnt_at_cap) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (dbg_req) begin
            state_d    = ST_DBG;
            cnt_d      = '0;
            last_dbg_d = 1'b0;
          end
        end else begin
          // A halt ends the CPU burst right after the grant of this cycle.
          state_d    = dbg_req ? ST_DBG : ST_IDLE;
          cnt_d      = '0;
          last_dbg_d = 1'b0;
        end
      end
      ST_DBG: begin
        if (dbg_req) begin
          if (!halt) begin
            if (!cnt_at_cap) begin
              cnt_d = cnt_q + CNT_W'(1);
            end else if (cpu_req) begin
              state_d    = ST_CPU;
              cnt_d      = '0;
              last_dbg_d = 1'b1;
            end
          end
        end else begin
          state_d    = cpu_ok ? ST_CPU : ST_IDLE;
          cnt_d      = '0;
          last_dbg_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      last_dbg_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_dbg_q <= last_dbg_d;
    end
  end

  // Capture read data at the end of each read grant cycle and route it to the port that issued the read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q <= cpu_gnt & ~cpu_we;
      dbg_rvalid_q <= dbg_gnt & ~dbg_we;
      if (cpu_gnt && !cpu_we) cpu_rdata_q <= mem_rdata;
      if (dbg_gnt && !dbg_we) dbg_rdata_q <= mem_rdata;
    end
  end

`ifdef RISC_V_MIKE_ARB_DBG_HALT_EN
  logic halt_ack_q;
  assign halt_ack = halt_ack_q;

  // Acknowledge the halt once the CPU will no longer own the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) halt_ack_q <= 1'b0;
    else      halt_ack_q <= dbg_halt & (state_d != ST_CPU);
  end
`endif

endmodule
